ram_stream_reader: RTL and testbench
====================================

// Module: ram_stream_reader
// PURPOSE
//   Read-side sequencer for the FFT sample RAM. On a start pulse it issues N reads on the
//   RAM read port (address + read enable, 1-cycle registered read latency) and streams the
//   returned words out over a valid/ready interface. Addresses are optionally bit-reversed.
//   Sits between the sample RAM and the butterfly datapath / output serializer.
// PARAMETERS
//   N        8   words per frame; power of two, >= 2; address width AW = log2(N)
//   I        4   integer bits per word
//   F        4   fractional bits per word; word width W = I+F
//   BIT_REV  1   1: address k is issued as bitrev_AW(k); 0: natural order k
// PORTS
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous, active-low reset
//   i_start    in   1   start one frame read; sampled only in IDLE
//   o_busy     out  1   high in RUN and DRAIN
//   o_done     out  1   one-cycle pulse after final beat is accepted
//   o_rd_en    out  1   RAM read enable (combinational from registered state)
//   o_rd_addr  out  AW  RAM read address (combinational from issue counter)
//   i_rd_data  in   W   RAM read data, valid the cycle after o_rd_en was high
//   o_data     out  W   stream data (registered, head of 2-entry buffer)
//   o_valid    out  1   stream valid
//   i_ready    in   1   stream ready from consumer
//   o_last     out  1   high with o_valid on beat N-1
// BEHAVIOUR
//   Reset (rst low, async): state IDLE; counters, buffer, inflight flag cleared;
//     o_busy=0, o_done=0, o_rd_en=0, o_rd_addr=0, o_data=0, o_valid=0, o_last=0.
//   FSM: IDLE -> RUN when i_start=1 at a clock edge; i_start ignored outside IDLE.
//     RUN  -> DRAIN on the edge issuing read N-1.
//     DRAIN -> IDLE on the edge accepting beat N-1 (o_valid & i_ready & o_last);
//     o_done=1 for the cycle following that edge.
//   Issue: counter k = 0..N-1; o_rd_addr = BIT_REV ? bitrev(k) : k; o_rd_en only in RUN.
//     pop = o_valid & i_ready. Read issued when (occ + inflight - pop) < 2,
//     occ = buffer entries (0..2), inflight = read issued on previous edge.
//     Outside RUN: o_rd_en=0, o_rd_addr holds last value (0 after reset).
//   Capture: when inflight=1, i_rd_data written to buffer tail that edge; simultaneous
//     push and pop is legal; buffer never overflows (credit rule above guarantees it).
//   Stream: o_data/o_valid reflect buffer head; o_data holds stable while o_valid=1 and
//     i_ready=0. o_last derived from a beat counter (accepted beats = N-1).
//   Latency: i_start sampled at edge E0 -> o_rd_en high after E0 -> o_valid high after E2.
//   Throughput: with i_ready held 1, one beat per cycle, N beats in N consecutive cycles.
//   Backpressure: i_ready=0 for any duration loses/duplicates no word; at most 2 reads
//     outstanding beyond the head beat.
//   Counters wrap to 0 when a frame ends; next frame may start the cycle after o_done.
//   Reset mid-frame: frame abandoned, no o_done; stream restarts only on a new i_start.
// TESTING
//   1. N=8, BIT_REV=1, RAM[a]=a+0x10, i_ready=1, start pulse -> o_data 0x10,14,12,16,
//      11,15,13,17 on 8 consecutive cycles, o_last on 0x17, o_done next cycle.
//   2. BIT_REV=0, same RAM -> o_data 0x10..0x17 in order; first o_valid 3 edges after start.
//   3. i_ready toggled 1,0,0,1 repeating -> same 8 words, none lost/duplicated, o_data stable
//      while stalled; o_rd_en never pushes occ above 2.
//   4. i_start pulsed while o_busy=1 -> ignored; exactly 8 beats and one o_done.
//   5. rst driven low after 3 accepted beats -> all outputs 0 immediately (async); new start
//      -> full frame from beat 0 (0x10 first).
//   6. Back-to-back frames: start the cycle after o_done -> second frame identical, k wraps.

Source files
------------

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Read-side sequencer for the FFT sample RAM. A start pulse launches one frame:
//   N reads are issued on the RAM read port (1-cycle registered read latency) and the
//   returned words are streamed out over valid/ready through a 2-entry buffer.
//   Read addresses are optionally bit-reversed.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   i_start    start one frame (only honoured in IDLE)
//   o_busy     frame in progress (RUN or DRAIN)
//   o_done     one-cycle pulse after the final beat is accepted
//   o_rd_en    RAM read enable
//   o_rd_addr  RAM read address
//   i_rd_data  RAM read data, valid the cycle after o_rd_en
//   o_data     stream data (buffer head)
//   o_valid    stream valid
//   i_ready    stream ready
//   o_last     marks beat N-1
module ram_stream_reader #(
    parameter int N       = 8,
    parameter int I       = 4,
    parameter int F       = 4,
    parameter bit BIT_REV = 1'b1,
    localparam int AW     = $clog2(N),
    localparam int W      = I + F
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    input  logic [W-1:0]  i_rd_data,
    output logic [W-1:0]  o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_last
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    logic [1:0]    state;
    logic [AW-1:0] k;         // issue counter
    logic [AW-1:0] beat;      // accepted-beat counter
    logic [1:0]    occ;       // buffer entries held
    logic          inflight;  // read issued on the previous edge, data arrives now
    logic [W-1:0]  buf0;      // head
    logic [W-1:0]  buf1;      // tail (only used when occ == 2)
    logic          done_q;

    logic          pop;
    logic [2:0]    credit;
    logic          rd_en;
    logic          last_beat;
    logic          frame_end;

    function automatic logic [AW-1:0] addr_map(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        return BIT_REV ? r : a;
    endfunction

    assign pop       = (occ != 2'd0) && i_ready;
    // Slots committed after this edge: buffered + arriving - leaving. Issue only if
    // that leaves room for the word this read will return next cycle.
    assign credit    = 3'(occ) + 3'(inflight) - 3'(pop);
    assign rd_en     = (state == S_RUN) && (credit < 3'd2);
    assign last_beat = (occ != 2'd0) && (beat == LAST_IDX);
    assign frame_end = (state == S_DRAIN) && pop && last_beat;

    // FSM and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            k        <= '0;
            beat     <= '0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            inflight <= rd_en;
            done_q   <= frame_end;

            case (state)
                S_IDLE:  if (i_start) state <= S_RUN;
                S_RUN:   if (rd_en && k == LAST_IDX) state <= S_DRAIN;
                S_DRAIN: if (frame_end) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // k parks on N-1 through DRAIN so the address holds, then wraps at frame end.
            if (rd_en && k != LAST_IDX)
                k <= k + 1'b1;
            else if (frame_end)
                k <= '0;

            if (pop)
                beat <= (beat == LAST_IDX) ? '0 : beat + 1'b1;
        end
    end

    // 2-entry buffer: head in buf0, pop shifts tail forward.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ  <= 2'd0;
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= i_rd_data;
                    else             buf1 <= i_rd_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= i_rd_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= i_rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy    = (state != S_IDLE);
    assign o_done    = done_q;
    assign o_rd_en   = rd_en;
    assign o_rd_addr = addr_map(k);
    assign o_data    = buf0;
    assign o_valid   = (occ != 2'd0);
    assign o_last    = last_beat;

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader
//   Directed bench: two instances (bit-reversed and natural order) each fed by a
//   1-cycle-latency RAM model holding RAM[a] = a + 0x10.
module tb_ram_stream_reader;

    logic       clk;
    logic       rst;
    logic       start   [2];
    logic       ready   [2];
    logic       busy    [2];
    logic       done    [2];
    logic       rd_en   [2];
    logic [2:0] rd_addr [2];
    logic [7:0] rd_data [2];
    logic [7:0] data    [2];
    logic       valid   [2];
    logic       last    [2];

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_rev [8] = '{8'h10, 8'h14, 8'h12, 8'h16, 8'h11, 8'h15, 8'h13, 8'h17};
    logic [7:0] exp_nat [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};

    ram_stream_reader #(.N(8), .I(4), .F(4), .BIT_REV(1'b1)) u_rev (
        .clk(clk), .rst(rst), .i_start(start[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_rd_en(rd_en[0]), .o_rd_addr(rd_addr[0]), .i_rd_data(rd_data[0]),
        .o_data(data[0]), .o_valid(valid[0]), .i_ready(ready[0]), .o_last(last[0])
    );

    ram_stream_reader #(.N(8), .I(4), .F(4), .BIT_REV(1'b0)) u_nat (
        .clk(clk), .rst(rst), .i_start(start[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_rd_en(rd_en[1]), .o_rd_addr(rd_addr[1]), .i_rd_data(rd_data[1]),
        .o_data(data[1]), .o_valid(valid[1]), .i_ready(ready[1]), .o_last(last[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read, contents a + 0x10
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            if (rd_en[d]) rd_data[d] <= {5'b00010, rd_addr[d]};
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One frame on instance d. mode 0: ready held 1; mode 1: ready 1,0,0,1 repeating.
    // extra: pulse i_start again mid-frame (must be ignored).
    task automatic run_frame(input int d, input int mode, input bit extra);
        int beat, first_v, last_acc, dones, done_cyc;
        bit stalled;
        logic [7:0] held, expd;
        beat = 0; first_v = -1; last_acc = -1; dones = 0; done_cyc = -1;
        stalled = 1'b0; held = '0;
        start[d] = 1'b1;
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start[d] = extra && (cyc == 5);
            ready[d] = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 1);
            if (stalled) begin
                chk("hold_valid", valid[d], 1);
                chk("hold_data", data[d], held);
            end
            if (done[d]) begin
                dones++;
                done_cyc = cyc;
            end
            if (valid[d] && first_v < 0) first_v = cyc;
            if (valid[d] && ready[d]) begin
                if (beat < 8) begin
                    expd = (d == 0) ? exp_rev[beat] : exp_nat[beat];
                    chk("data", data[d], expd);
                    chk("last", last[d], (beat == 7));
                end
                beat++;
                if (beat == 8) last_acc = cyc;
            end
            stalled = valid[d] && !ready[d];
            held    = data[d];
        end
        ready[d] = 1'b0;
        start[d] = 1'b0;
        chk("beats", beat, 8);
        chk("done_count", dones, 1);
        chk("done_timing", done_cyc, last_acc + 1);
        chk("first_valid", first_v, 3);
        chk("busy_at_done", busy[d], 0);
        if (mode == 0) chk("throughput", last_acc, 10);
    endtask

    initial begin
        int beat;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", busy[d], 0);
            chk("rst_done", done[d], 0);
            chk("rst_rd_en", rd_en[d], 0);
            chk("rst_rd_addr", rd_addr[d], 0);
            chk("rst_data", data[d], 0);
            chk("rst_valid", valid[d], 0);
            chk("rst_last", last[d], 0);
        end
        rst = 1'b1;
        @(negedge clk);

        run_frame(0, 0, 1'b0);   // bit-reversed, full rate
        run_frame(1, 0, 1'b0);   // natural order, full rate
        run_frame(0, 1, 1'b0);   // backpressure 1,0,0,1
        run_frame(1, 0, 1'b1);   // start pulsed while busy
        run_frame(0, 0, 1'b0);   // back-to-back frames
        run_frame(0, 0, 1'b0);
        run_frame(1, 1, 1'b0);

        // Reset after 3 accepted beats
        @(negedge clk);
        beat = 0;
        start[0] = 1'b1;
        ready[0] = 1'b1;
        for (int cyc = 0; cyc < 20 && beat < 3; cyc++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (valid[0] && ready[0]) beat++;
        end
        chk("pre_rst_beats", beat, 3);
        @(posedge clk);
        #2;
        chk("pre_rst_busy", busy[0], 1);
        rst = 1'b0;
        #1;
        chk("arst_busy", busy[0], 0);
        chk("arst_done", done[0], 0);
        chk("arst_rd_en", rd_en[0], 0);
        chk("arst_rd_addr", rd_addr[0], 0);
        chk("arst_data", data[0], 0);
        chk("arst_valid", valid[0], 0);
        chk("arst_last", last[0], 0);
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            chk("post_rst_idle_valid", valid[0], 0);
            chk("post_rst_idle_busy", busy[0], 0);
            chk("post_rst_idle_done", done[0], 0);
        end
        ready[0] = 1'b0;
        run_frame(0, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
